// File: rtl/neuron_accum.sv
// Neuron accumulator: bias plus N_TERMS signed sfix26_En18 terms with saturating
// adds, followed by ReLU and a valid/ready result handshake.
module neuron_accum #(
  parameter int N_TERMS = 784,
  parameter int CNT_W   = 10
) (
  input  logic        clk,
  input  logic        GlobalReset,
  input  logic        start,
  input  logic [25:0] bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [25:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [25:0] out_data,
  output logic        out_sat
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ACT   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
  localparam logic [25:0]      POS_MAX  = 26'h1FFFFFF;
  localparam logic [25:0]      NEG_MAX  = 26'h2000000;

  state_t           state_reg;
  logic [25:0]      acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             sat_reg;
  logic [25:0]      out_data_reg;
  logic             out_sat_reg;
  logic             out_valid_reg;

  logic [26:0] sum_ext;
  logic        ovf;
  logic [25:0] acc_next;

  // One guard bit: overflow shows as disagreement between bits 26 and 25.
  assign sum_ext = {acc_reg[25], acc_reg} + {in_data[25], in_data};
  assign ovf     = sum_ext[26] ^ sum_ext[25];

  always_comb begin
    acc_next = sum_ext[25:0];
    if (ovf) begin
      acc_next = sum_ext[26] ? NEG_MAX : POS_MAX;
    end
  end

  assign in_ready  = (state_reg == ACCUM);
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sat   = out_sat_reg;

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      sat_reg       <= 1'b0;
      out_data_reg  <= '0;
      out_sat_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            acc_reg   <= bias;
            cnt_reg   <= '0;
            sat_reg   <= 1'b0;
            state_reg <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_reg <= acc_next;
            if (ovf) begin
              sat_reg <= 1'b1;
            end
            if (cnt_reg == LAST_CNT) begin
              state_reg <= ACT;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        ACT: begin
          out_data_reg  <= acc_reg[25] ? 26'd0 : acc_reg;
          out_sat_reg   <= sat_reg;
          out_valid_reg <= 1'b1;
          state_reg     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accum.sv
// Directed bench for neuron_accum with N_TERMS=4: arithmetic, ReLU, saturation,
// flow control, asynchronous reset and ignored-input behaviour.
module tb_neuron_accum;

  logic        clk = 1'b0;
  logic        GlobalReset;
  logic        start;
  logic [25:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] out_data;
  logic        out_sat;

  int errors = 0;
  int checks = 0;

  neuron_accum #(.N_TERMS(4), .CNT_W(2)) dut (
    .clk        (clk),
    .GlobalReset(GlobalReset),
    .start      (start),
    .bias       (bias),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start a neuron, feed four terms, check the ACT gap and the registered result.
  task automatic run_neuron(input string tag, input logic [25:0] b,
                            input logic [25:0] t0, input logic [25:0] t1,
                            input logic [25:0] t2, input logic [25:0] t3,
                            input bit toggle, input bit start_noise,
                            input logic [25:0] exp_d, input logic exp_s);
    logic [25:0] terms [4];
    terms[0] = t0; terms[1] = t1; terms[2] = t2; terms[3] = t3;
    chk({tag, ".idle_ready"}, 32'(in_ready), 32'd0);
    start = 1'b1;
    bias  = b;
    tick();
    start = start_noise;
    bias  = 26'h0AAAAAA;
    chk({tag, ".accum_ready"}, 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (toggle && i > 0) begin
        in_valid = 1'b0;
        in_data  = 26'h1555555;
        tick();
      end
      in_valid = 1'b1;
      in_data  = terms[i];
      tick();
    end
    in_valid = 1'b0;
    in_data  = 26'h0;
    start    = 1'b0;
    chk({tag, ".act_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".act_ready"}, 32'(in_ready), 32'd0);
    tick();
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"}, 32'(out_data), 32'(exp_d));
    chk({tag, ".sat"}, 32'(out_sat), 32'(exp_s));
    $display("neuron %s: bias=%h data=%h sat=%0b", tag, b, out_data, out_sat);
  endtask

  task automatic handshake(input string tag, input logic [25:0] exp_d);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".hs_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".hs_data_kept"}, 32'(out_data), 32'(exp_d));
  endtask

  initial begin
    GlobalReset = 1'b0;
    start       = 1'b0;
    bias        = 26'h0;
    in_valid    = 1'b0;
    in_data     = 26'h0;
    out_ready   = 1'b0;
    #2;
    chk("reset.valid", 32'(out_valid), 32'd0);
    chk("reset.data", 32'(out_data), 32'd0);
    chk("reset.sat", 32'(out_sat), 32'd0);
    chk("reset.ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    GlobalReset = 1'b1;
    tick();

    // 0x40000 + 0x40000 + 0x20000 - 0x20000 + 0 = 0x80000 (2.0)
    run_neuron("basic", 26'h0040000, 26'h0040000, 26'h0020000, 26'h3FE0000, 26'h0, 0, 0,
               26'h0080000, 1'b0);
    handshake("basic", 26'h0080000);

    // 4 * -2 LSB = -8 LSB, clipped to zero by ReLU
    run_neuron("relu", 26'h0, 26'h3FFFFFE, 26'h3FFFFFE, 26'h3FFFFFE, 26'h3FFFFFE, 0, 0,
               26'h0, 1'b0);
    handshake("relu", 26'h0);

    run_neuron("sat_pos", 26'h1FFFFFF, 26'h1, 26'h0, 26'h0, 26'h0, 0, 0,
               26'h1FFFFFF, 1'b1);
    handshake("sat_pos", 26'h1FFFFFF);

    run_neuron("sat_neg", 26'h2000000, 26'h3FFFFFF, 26'h0, 26'h0, 26'h0, 0, 0,
               26'h0, 1'b1);
    handshake("sat_neg", 26'h0);

    // A fresh neuron must clear the sticky flag
    run_neuron("sat_clr", 26'h0000010, 26'h1, 26'h1, 26'h1, 26'h1, 0, 0,
               26'h0000014, 1'b0);
    handshake("sat_clr", 26'h0000014);

    run_neuron("flow", 26'h0040000, 26'h0040000, 26'h0020000, 26'h3FE0000, 26'h0, 1, 0,
               26'h0080000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("flow.stall_valid", 32'(out_valid), 32'd1);
      chk("flow.stall_data", 32'(out_data), 32'h0080000);
      chk("flow.stall_ready", 32'(in_ready), 32'd0);
    end
    handshake("flow", 26'h0080000);
    // Back in IDLE: a start is taken on the very next edge
    start = 1'b1;
    bias  = 26'h0;
    tick();
    start = 1'b0;
    chk("flow.idle_restart", 32'(in_ready), 32'd1);

    // Two terms into that neuron, then reset asynchronously between edges
    in_valid = 1'b1;
    in_data  = 26'h0000100;
    tick();
    tick();
    in_valid = 1'b0;
    #2;
    GlobalReset = 1'b0;
    #1;
    chk("rst_mid.ready", 32'(in_ready), 32'd0);
    chk("rst_mid.data", 32'(out_data), 32'd0);
    chk("rst_mid.valid", 32'(out_valid), 32'd0);
    chk("rst_mid.sat", 32'(out_sat), 32'd0);
    tick();
    GlobalReset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_mid.no_valid", 32'(out_valid), 32'd0);
    end
    run_neuron("rst_after", 26'h0040000, 26'h0040000, 26'h0020000, 26'h3FE0000, 26'h0, 0, 0,
               26'h0080000, 1'b0);
    handshake("rst_after", 26'h0080000);

    // in_valid while idle must not start or alter anything
    in_valid = 1'b1;
    in_data  = 26'h0123456;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ign.idle_ready", 32'(in_ready), 32'd0);
      chk("ign.idle_valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    // start held high through accumulation
    run_neuron("ign", 26'h0040000, 26'h0040000, 26'h0020000, 26'h3FE0000, 26'h0, 1, 1,
               26'h0080000, 1'b0);
    start = 1'b1;
    bias  = 26'h1000000;
    tick();
    tick();
    start = 1'b0;
    chk("ign.hold_valid", 32'(out_valid), 32'd1);
    chk("ign.hold_data", 32'(out_data), 32'h0080000);
    handshake("ign", 26'h0080000);
    tick();
    chk("ign.stay_idle", 32'(in_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
